crc_parallel_engine: RTL and testbench
======================================

Name: crc_parallel_engine

Overview:
- Parametrised successor to the serial CRC generators: updates a CRC register by DATA_W message bits per clock instead of 1.
- Adds framed valid/ready input handshake, optional per-byte input reflection, output reflection, and a registered result with a valid flag.
- Sits between a word-wide data source (FIFO or packet datapath) and a frame checker or inserter; replaces the parallel_to_serial + crc_static pair where throughput matters.

Parameters:
- CRC_SIZE, 16, CRC width in bits; all following CRC-valued parameters have this width.
- DATA_W, 8, message bits consumed per accepted word; 1..64; must be a multiple of 8 when REFLECT_IN=1.
- INITIAL_VAL, 16'hFFFF, value loaded into the CRC register on start.
- CRC_POLY, 16'h1021, generator polynomial, implicit top bit omitted.
- FINAL_XOR, 16'h0000, XORed into the result after optional output reflection.
- REFLECT_IN, 0, 1 = each byte of din is bit-reversed before processing.
- REFLECT_OUT, 0, 1 = the whole CRC register is bit-reversed before FINAL_XOR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a new frame.
- din  in  DATA_W  message word; most-significant byte/bit goes first.
- din_valid  in  1  din holds a valid word.
- din_last  in  1  qualifies din_valid: this is the final word of the frame.
- din_ready  out  1  engine accepts din this cycle.
- crc  out  CRC_SIZE  final CRC of the last completed frame.
- crc_valid  out  1  crc holds a completed result.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, CRC register=INITIAL_VAL, crc=0, crc_valid=0.
  - busy=0 and din_ready=0.
  - Reset has priority over every other input, including mid-frame; any partial frame is discarded.
- States are IDLE and RUN.
  - busy=1 exactly when state==RUN.
  - din_ready = (state==RUN) & ~start. This is combinational; a word offered together with start is never accepted.
- IDLE:
  - start=1 -> register<=INITIAL_VAL, crc_valid<=0, state<=RUN.
  - din_valid is ignored.
  - crc and crc_valid keep the previous result.
- RUN, word accepted (din_valid & din_ready):
  - Register is updated in one cycle by DATA_W unrolled serial steps, processed in order from bit DATA_W-1 down to 0 (after optional per-byte reflection).
  - Each step: fb = reg[CRC_SIZE-1] ^ bit; reg = (reg<<1) ^ (fb ? CRC_POLY : 0).
- RUN, accepted word has din_last=1:
  - crc <= (REFLECT_OUT ? reverse(next_reg) : next_reg) ^ FINAL_XOR.
  - crc_valid<=1, state<=IDLE.
  - Latency: crc_valid rises at the clock edge that accepts the last word; crc is visible in the following cycle.
- RUN, din_valid=0: register holds. Idle gaps of any length are allowed.
- RUN, start=1: abort and restart. Register<=INITIAL_VAL and state stays RUN; no result is produced for the aborted frame.
- Cycle after a frame completes:
  - A start pulse may arrive in this cycle (IDLE); back-to-back frames lose one cycle.
  - crc_valid stays 1 until the next start or reset.
- din_last without din_valid has no effect.
- Frames are whole words only; a partial final word is not supported.
- Behaviour with DATA_W=1 and REFLECT_*=0 must be bit-identical to crc_static fed the same serial stream.

Test Plan:
- CRC-16/CCITT-FALSE (defaults), DATA_W=8, bytes "123456789" (0x31..0x39), last on 0x39 -> crc=16'h29B1, crc_valid=1 one edge after last accept.
- CRC-32:
  - Setup: CRC_SIZE=32, DATA_W=8, INITIAL_VAL=32'hFFFFFFFF, POLY=32'h04C11DB7, FINAL_XOR=32'hFFFFFFFF, REFLECT_IN=1, REFLECT_OUT=1.
  - Stimulus: "123456789".
  - Required: crc=32'hCBF43926.
- Width equivalence:
  - Setup: defaults, 128'hFFFF...FF, then 128'h0, then 5 random 128-bit vectors.
  - Stimulus: feed each via DATA_W=1 (one bit/word), DATA_W=16 (8 words) and crc_static.
  - Required: all three CRCs are identical per vector.
- Handshake stress: DATA_W=8 "123456789" with random din_valid gaps (0-3 cycles) -> crc=16'h29B1; din_ready=0 in IDLE; no word accepted twice.
- Abort:
  - Stimulus: send 0x31,0x32, pulse start together with din_valid=1 (0x33); din_ready=0 that cycle. Then send "123456789".
  - Required: crc=16'h29B1, and crc_valid does not pulse for the aborted frame.
- Reset mid-frame: rst=0 for one cycle after 4 bytes -> busy=0, crc=0, crc_valid=0 next cycle; subsequent full frame gives 16'h29B1.

Source files
------------

// File: rtl/crc_parallel_engine_if.sv
// Bus bundle for crc_parallel_engine: framed word input handshake plus the
// registered CRC result and status flags.
interface crc_parallel_engine_if #(
  parameter int unsigned CRC_SIZE = 16,
  parameter int unsigned DATA_W   = 8
);
  logic                start;
  logic [DATA_W-1:0]   din;
  logic                din_valid;
  logic                din_last;
  logic                din_ready;
  logic [CRC_SIZE-1:0] crc;
  logic                crc_valid;
  logic                busy;

  // Data source side.
  modport master (
    output start, din, din_valid, din_last,
    input  din_ready, crc, crc_valid, busy
  );

  // CRC engine side.
  modport slave (
    input  start, din, din_valid, din_last,
    output din_ready, crc, crc_valid, busy
  );
endinterface

// File: rtl/crc_parallel_engine.sv
// Word-parallel CRC engine: folds DATA_W message bits into the CRC register
// per accepted word, with framed valid/ready input, optional per-byte input
// reflection, output reflection and a registered final result.
// The interface instance must carry the same CRC_SIZE/DATA_W as this module.
module crc_parallel_engine #(
  parameter int unsigned         CRC_SIZE    = 16,
  parameter int unsigned         DATA_W      = 8,
  parameter logic [CRC_SIZE-1:0] INITIAL_VAL = 16'hFFFF,
  parameter logic [CRC_SIZE-1:0] CRC_POLY    = 16'h1021,
  parameter logic [CRC_SIZE-1:0] FINAL_XOR   = 16'h0000,
  parameter bit                  REFLECT_IN  = 1'b0,
  parameter bit                  REFLECT_OUT = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  crc_parallel_engine_if.slave bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CRC_SIZE-1:0] r_crc_reg;
  logic [CRC_SIZE-1:0] r_crc;
  logic                r_crc_valid;

  logic                w_din_ready;
  logic                w_busy;
  logic                w_accept;
  logic [DATA_W-1:0]   w_din_proc;
  logic [DATA_W-1:0]   w_shift;
  logic                w_fb;
  logic [CRC_SIZE-1:0] w_next;
  logic [CRC_SIZE-1:0] w_next_rev;
  logic [CRC_SIZE-1:0] w_result;

  assign w_accept = bus.din_valid & w_din_ready;

  // Optional bit reversal inside each byte of the incoming word.
  if (REFLECT_IN) begin : g_refl_in
    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
      for (genvar k = 0; k < 8; k++) begin : g_bit
        assign w_din_proc[b*8+k] = bus.din[b*8+7-k];
      end
    end
  end else begin : g_no_refl_in
    assign w_din_proc = bus.din;
  end

  // Unrolled serial LFSR steps, word MSB first; the word is shifted left so
  // every step reads a fixed bit position regardless of DATA_W.
  always_comb begin
    w_next  = r_crc_reg;
    w_shift = w_din_proc;
    w_fb    = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_fb    = w_next[CRC_SIZE-1] ^ w_shift[DATA_W-1];
      w_next  = (w_next << 1) ^ (w_fb ? CRC_POLY : '0);
      w_shift = w_shift << 1;
    end
  end

  // Whole-register reversal for reflected output.
  for (genvar j = 0; j < CRC_SIZE; j++) begin : g_rev
    assign w_next_rev[j] = w_next[CRC_SIZE-1-j];
  end

  assign w_result = (REFLECT_OUT ? w_next_rev : w_next) ^ FINAL_XOR;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state: start always (re)enters RUN; the last accepted word returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && bus.din_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; a word offered alongside start is never taken.
  always_comb begin
    w_busy      = (r_state == S_RUN);
    w_din_ready = (r_state == S_RUN) && !bus.start;
  end

  // CRC register and result: start reloads, accepted words fold in, last word publishes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_crc_reg   <= INITIAL_VAL;
      r_crc       <= '0;
      r_crc_valid <= 1'b0;
    end else if (bus.start) begin
      r_crc_reg   <= INITIAL_VAL;
      r_crc_valid <= 1'b0;
    end else if (w_accept) begin
      r_crc_reg <= w_next;
      if (bus.din_last) begin
        r_crc       <= w_result;
        r_crc_valid <= 1'b1;
      end
    end
  end

  assign bus.din_ready = w_din_ready;
  assign bus.busy      = w_busy;
  assign bus.crc       = r_crc;
  assign bus.crc_valid = r_crc_valid;

endmodule

// File: tb/tb_crc_parallel_engine.sv
// Directed bench for crc_parallel_engine: CRC-16/CCITT-FALSE and CRC-32 on a
// shared byte bus, plus DATA_W=1 and DATA_W=16 instances for width equivalence.
module tb_crc_parallel_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Shared byte-wide stimulus for the CRC-16 and CRC-32 instances.
  logic       s8 = 1'b0, v8 = 1'b0, l8 = 1'b0;
  logic [7:0] d8 = '0;
  // Bit-serial and 16-bit instances.
  logic        s1 = 1'b0, v1 = 1'b0, l1 = 1'b0, d1 = 1'b0;
  logic        s16 = 1'b0, v16 = 1'b0, l16 = 1'b0;
  logic [15:0] d16 = '0;

  crc_parallel_engine_if #(.CRC_SIZE(16), .DATA_W(8))  if8  ();
  crc_parallel_engine_if #(.CRC_SIZE(32), .DATA_W(8))  if32 ();
  crc_parallel_engine_if #(.CRC_SIZE(16), .DATA_W(1))  if1  ();
  crc_parallel_engine_if #(.CRC_SIZE(16), .DATA_W(16)) if16 ();

  assign if8.start  = s8;  assign if8.din  = d8;  assign if8.din_valid  = v8;  assign if8.din_last  = l8;
  assign if32.start = s8;  assign if32.din = d8;  assign if32.din_valid = v8;  assign if32.din_last = l8;
  assign if1.start  = s1;  assign if1.din  = d1;  assign if1.din_valid  = v1;  assign if1.din_last  = l1;
  assign if16.start = s16; assign if16.din = d16; assign if16.din_valid = v16; assign if16.din_last = l16;

  crc_parallel_engine #(.CRC_SIZE(16), .DATA_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  crc_parallel_engine #(
    .CRC_SIZE(32), .DATA_W(8), .INITIAL_VAL(32'hFFFFFFFF), .CRC_POLY(32'h04C11DB7),
    .FINAL_XOR(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
  ) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  crc_parallel_engine #(.CRC_SIZE(16), .DATA_W(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  crc_parallel_engine #(.CRC_SIZE(16), .DATA_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  // Accepted-word and crc_valid rising-edge counters on the byte bus.
  int unsigned acc_cnt  = 0;
  int unsigned rise_cnt = 0;
  logic        prev_cv  = 1'b0;
  always @(posedge clk) begin
    if (v8 && if8.din_ready) acc_cnt++;
    if (if8.crc_valid && !prev_cv) rise_cnt++;
    prev_cv = if8.crc_valid;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Serial CRC-16/CCITT-FALSE over the top nbits of m, MSB first.
  function automatic logic [15:0] crc16_bits(input logic [127:0] m, input int unsigned nbits);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int unsigned k = 0; k < nbits; k++) begin
      fb = c[15] ^ m[127-k];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Reflected-table-free CRC-32 over the first nbytes of m.
  function automatic logic [31:0] crc32_ref(input logic [127:0] m, input int unsigned nbytes);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int unsigned k = 0; k < nbytes; k++) begin
      b = m[127-8*k -: 8];
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic start8();
    @(negedge clk); s8 = 1'b1;
    @(posedge clk); #1; s8 = 1'b0;
    chk("busy_after_start", if8.busy, 1);
    chk("cv_cleared_by_start", if8.crc_valid, 0);
  endtask

  task automatic send8(input logic [7:0] b, input bit last, input int unsigned gap);
    int unsigned n;
    for (int unsigned g = 0; g < gap; g++) begin @(negedge clk); v8 = 1'b0; end
    @(negedge clk);
    d8 = b; v8 = 1'b1; l8 = last;
    #1;
    n = 0;
    while (!if8.din_ready && n < 16) begin @(negedge clk); #1; n++; end
    if (n >= 16) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: din_ready=0 for %0d cycles, required 1", n);
    end
    if (last) chk("cv_low_before_last_edge", if8.crc_valid, 0);
    @(posedge clk); #1;
    v8 = 1'b0; l8 = 1'b0;
  endtask

  task automatic send_digits();
    logic [71:0] s;
    s = 72'h313233343536373839;
    for (int k = 0; k < 9; k++) send8(s[71-8*k -: 8], k == 8, 0);
  endtask

  task automatic run_wide(input logic [127:0] vec);
    logic [15:0] exp;
    exp = crc16_bits(vec, 128);
    @(negedge clk); s1 = 1'b1; s16 = 1'b1;
    @(posedge clk); #1; s1 = 1'b0; s16 = 1'b0;
    fork
      begin
        for (int i = 127; i >= 0; i--) begin
          @(negedge clk); d1 = vec[i]; v1 = 1'b1; l1 = (i == 0);
          @(posedge clk); #1;
        end
        v1 = 1'b0; l1 = 1'b0;
      end
      begin
        for (int w = 0; w < 8; w++) begin
          @(negedge clk); d16 = vec[127-16*w -: 16]; v16 = 1'b1; l16 = (w == 7);
          @(posedge clk); #1;
        end
        v16 = 1'b0; l16 = 1'b0;
      end
    join
    chk("w1_crc", if1.crc, exp);
    chk("w1_valid", if1.crc_valid, 1);
    chk("w16_crc", if16.crc, exp);
    chk("w16_valid", if16.crc_valid, 1);
  endtask

  typedef struct {
    int unsigned  len;
    logic [127:0] data;
    int unsigned  gapmax;
    logic [15:0]  e16;
    logic [31:0]  e32;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int unsigned a0, r0;
    logic [15:0] last16;

    tbl[0] = '{len: 9,  data: {72'h313233343536373839, 56'h0}, gapmax: 0, e16: 16'h29B1, e32: 32'hCBF43926};
    tbl[1] = '{len: 9,  data: {72'h313233343536373839, 56'h0}, gapmax: 3, e16: 16'h29B1, e32: 32'hCBF43926};
    tbl[2] = '{len: 1,  data: {8'h61, 120'h0},                 gapmax: 0, e16: 16'h0,    e32: 32'hE8B7BE43};
    tbl[3] = '{len: 16, data: 128'h000102030405060708090A0B0C0D0E0F, gapmax: 1, e16: 16'h0, e32: 32'h0};
    tbl[4] = '{len: 1,  data: 128'h0,                          gapmax: 0, e16: 16'h0,    e32: 32'hD202EF8D};
    tbl[2].e16 = crc16_bits(tbl[2].data, 8);
    tbl[3].e16 = crc16_bits(tbl[3].data, 128);
    tbl[3].e32 = crc32_ref(tbl[3].data, 16);
    tbl[4].e16 = crc16_bits(tbl[4].data, 8);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_crc", if8.crc, 0);
    chk("rst_cv", if8.crc_valid, 0);
    chk("rst_busy", if8.busy, 0);
    chk("rst_ready", if8.din_ready, 0);
    chk("rst_crc32", if32.crc, 0);
    @(negedge clk); rst = 1'b1;

    // din_valid in IDLE is ignored and never accepted.
    @(negedge clk); d8 = 8'h55; v8 = 1'b1; l8 = 1'b1; #1;
    chk("idle_ready", if8.din_ready, 0);
    a0 = acc_cnt;
    repeat (2) @(posedge clk);
    #1; v8 = 1'b0; l8 = 1'b0;
    chk("idle_no_accept", acc_cnt - a0, 0);
    chk("idle_cv", if8.crc_valid, 0);

    // Table of byte frames; each next start lands in the cycle after completion.
    for (int v = 0; v < 5; v++) begin
      start8();
      a0 = acc_cnt;
      for (int unsigned k = 0; k < tbl[v].len; k++)
        send8(tbl[v].data[127-8*k -: 8], k == tbl[v].len - 1,
              (tbl[v].gapmax != 0) ? $urandom_range(tbl[v].gapmax, 0) : 0);
      chk("tbl_crc16", if8.crc, tbl[v].e16);
      chk("tbl_crc32", if32.crc, tbl[v].e32);
      chk("tbl_cv", if8.crc_valid, 1);
      chk("tbl_idle", if8.busy, 0);
      chk("tbl_accepts", acc_cnt - a0, tbl[v].len);
    end
    last16 = tbl[4].e16;

    // Result holds in IDLE while a word is offered.
    @(negedge clk); d8 = 8'hAA; v8 = 1'b1; l8 = 1'b1; #1;
    chk("hold_ready", if8.din_ready, 0);
    a0 = acc_cnt;
    repeat (3) @(posedge clk);
    #1; v8 = 1'b0; l8 = 1'b0;
    chk("hold_crc", if8.crc, last16);
    chk("hold_cv", if8.crc_valid, 1);
    chk("hold_no_accept", acc_cnt - a0, 0);

    // Abort: start with a word offered restarts the frame, word not taken.
    start8();
    send8(8'h31, 1'b0, 0);
    send8(8'h32, 1'b0, 0);
    r0 = rise_cnt;
    @(negedge clk); s8 = 1'b1; d8 = 8'h33; v8 = 1'b1; l8 = 1'b0; #1;
    chk("abort_ready", if8.din_ready, 0);
    a0 = acc_cnt;
    @(posedge clk); #1; s8 = 1'b0; v8 = 1'b0;
    chk("abort_no_accept", acc_cnt - a0, 0);
    chk("abort_busy", if8.busy, 1);
    send_digits();
    @(posedge clk); #1;
    chk("abort_crc16", if8.crc, 16'h29B1);
    chk("abort_crc32", if32.crc, 32'hCBF43926);
    chk("abort_single_pulse", rise_cnt - r0, 1);

    // Reset mid-frame discards the partial frame and the previous result.
    start8();
    for (int k = 0; k < 4; k++) send8(8'h31 + 8'(k), 1'b0, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", if8.busy, 0);
    chk("midrst_crc", if8.crc, 0);
    chk("midrst_cv", if8.crc_valid, 0);
    chk("midrst_ready", if8.din_ready, 0);
    rst = 1'b1;
    start8();
    send_digits();
    chk("postrst_crc16", if8.crc, 16'h29B1);
    chk("postrst_crc32", if32.crc, 32'hCBF43926);

    // Width equivalence: DATA_W=1 and DATA_W=16 against the serial reference.
    run_wide('1);
    run_wide('0);
    for (int r = 0; r < 5; r++) run_wide({$urandom, $urandom, $urandom, $urandom});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
